// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares a single floating-point multiplier between NREQ
// requesters. Round-robin grant, one operation in flight, operands
// registered towards the multiplier, product returned tagged with the
// requester index over a valid/ready response port.
module fmul_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [N-1:0]      mul_out
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  id_p0;
  logic [CW-1:0]   cnt_p0;
  logic [IDW-1:0]  grant;
  logic            grant_vld;
  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and grant decode; req_ready is only ever raised in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          state_d          = BUSY;
        end
      end
      BUSY: begin
        if (cnt_p0 == CW'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: operands captured on accept, held stable while BUSY ----
  // Operand registers, grant history and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      id_p0  <= '0;
      last_q <= IDW'(NREQ - 1);
      cnt_p0 <= '0;
    end else begin
      if (state_q == IDLE && grant_vld) begin
        mul_a  <= a_arr[grant];
        mul_b  <= b_arr[grant];
        id_p0  <= grant;
        last_q <= grant;
        cnt_p0 <= CW'(LAT);
      end else if (state_q == BUSY) begin
        cnt_p0 <= cnt_p0 - CW'(1);
      end
    end
  end

  // ---- stage p1: product captured when the multiplier latency expires ----
  // Response register, held until the consumer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (state_q == BUSY && cnt_p0 == CW'(1)) begin
        rsp_data  <= mul_out;
        rsp_id    <= id_p0;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: directed bench for fmul_arbiter with LAT=1 and LAT=3
// instances, each attached to a small multiplier stand-in.
module tb_fmul_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Operands and hand-computed IEEE-754 single products per requester.
  logic [31:0] op_a  [4] = '{32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h40800000};
  logic [31:0] op_b  [4] = '{32'h40400000, 32'h40A00000, 32'h3FC00000, 32'h3F000000};
  logic [31:0] exp_p [4] = '{32'h40C00000, 32'h40A00000, 32'h40100000, 32'h40000000};

  // Multiplier stand-in: exact for the operand pairs used, scrambled otherwise.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3F800000 && b == 32'h40A00000) return 32'h40A00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'h40800000 && b == 32'h3F000000) return 32'h40000000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  // LAT=1 instance
  logic [NREQ-1:0]   req_valid1, req_ready1;
  logic [NREQ*N-1:0] req_a1, req_b1;
  logic              rsp_valid1, rsp_ready1;
  logic [1:0]        rsp_id1;
  logic [N-1:0]      rsp_data1, mul_a1, mul_b1, mul_out1;

  assign mul_out1 = fmul_model(mul_a1, mul_b1);

  fmul_arbiter #(.N(N), .NREQ(NREQ), .LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_id(rsp_id1), .rsp_data(rsp_data1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_out(mul_out1)
  );

  // LAT=3 instance with a two-register multiplier pipeline
  logic [NREQ-1:0]   req_valid3, req_ready3;
  logic [NREQ*N-1:0] req_a3, req_b3;
  logic              rsp_valid3, rsp_ready3;
  logic [1:0]        rsp_id3;
  logic [N-1:0]      rsp_data3, mul_a3, mul_b3, mul_out3;
  logic [N-1:0]      pipe1, pipe2;

  always_ff @(posedge clk) begin
    pipe1 <= fmul_model(mul_a3, mul_b3);
    pipe2 <= pipe1;
  end
  assign mul_out3 = pipe2;

  fmul_arbiter #(.N(N), .NREQ(NREQ), .LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .mul_a(mul_a3), .mul_b(mul_b3), .mul_out(mul_out3)
  );

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready1 !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready1); end
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid1); end
    total++; if (rsp_id1 !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id1); end
    total++; if (rsp_data1 !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data1); end
    total++; if (mul_a1 !== 32'h0 || mul_b1 !== 32'h0) begin bad++; $display("FAIL reset_mul_ab: got %h/%h want 0/0", mul_a1, mul_b1); end
    total++; if (rsp_valid3 !== 1'b0 || req_ready3 !== 4'b0000) begin bad++; $display("FAIL reset_lat3: got %b/%b want 0/0000", rsp_valid3, req_ready3); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready1 !== 4'b0000) begin bad++; $display("FAIL idle_no_req: got %b want 0000", req_ready1); end
  endtask

  task automatic test_basic();
    req_valid1 = 4'b0001; rsp_ready1 = 1'b0; #1;
    total++; if (req_ready1 !== 4'b0001) begin bad++; $display("FAIL basic_grant: got %b want 0001", req_ready1); end
    @(negedge clk); req_valid1 = 4'b0000; #1;
    total++; if (req_ready1 !== 4'b0000) begin bad++; $display("FAIL basic_busy_ready: got %b want 0000", req_ready1); end
    total++; if (mul_a1 !== op_a[0] || mul_b1 !== op_b[0]) begin bad++; $display("FAIL basic_mul_ab: got %h/%h want %h/%h", mul_a1, mul_b1, op_a[0], op_b[0]); end
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", rsp_valid1); end
    @(negedge clk);
    total++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd0) begin bad++; $display("FAIL basic_rsp: got v=%b id=%0d want v=1 id=0", rsp_valid1, rsp_id1); end
    total++; if (rsp_data1 !== 32'h40C00000) begin bad++; $display("FAIL basic_data: got %h want 40c00000", rsp_data1); end
    rsp_ready1 = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL basic_handshake: got %b want 0", rsp_valid1); end
    rsp_ready1 = 1'b0;
  endtask

  task automatic test_round_robin();
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    req_valid1 = 4'b1111; rsp_ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      #1;
      total++; if (req_ready1 !== 4'(1 << g)) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready1, 4'(1 << g)); end
      @(negedge clk);
      total++; if (req_ready1 !== 4'b0000) begin bad++; $display("FAIL rr_busy%0d: got %b want 0000", k, req_ready1); end
      @(negedge clk);
      total++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'(g)) begin bad++; $display("FAIL rr_rsp%0d: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid1, rsp_id1, g); end
      total++; if (rsp_data1 !== exp_p[g]) begin bad++; $display("FAIL rr_data%0d: got %h want %h", k, rsp_data1, exp_p[g]); end
      @(negedge clk);
    end
    req_valid1 = 4'b0000; rsp_ready1 = 1'b0;
  endtask

  task automatic test_stall();
    req_valid1 = 4'b0010; rsp_ready1 = 1'b0; #1;
    total++; if (req_ready1 !== 4'b0010) begin bad++; $display("FAIL stall_grant: got %b want 0010", req_ready1); end
    @(negedge clk); req_valid1 = 4'b1111;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      total++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd1 || rsp_data1 !== exp_p[1]) begin bad++; $display("FAIL stall_hold%0d: got v=%b id=%0d d=%h want v=1 id=1 d=%h", c, rsp_valid1, rsp_id1, rsp_data1, exp_p[1]); end
      total++; if (req_ready1 !== 4'b0000) begin bad++; $display("FAIL stall_ready%0d: got %b want 0000", c, req_ready1); end
      @(negedge clk);
    end
    rsp_ready1 = 1'b1; req_valid1 = 4'b0000;
    @(negedge clk);
    rsp_ready1 = 1'b0;
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", rsp_valid1); end
    req_valid1 = 4'b0001; #1;
    total++; if (req_ready1 !== 4'b0001) begin bad++; $display("FAIL stall_idle_next: got %b want 0001", req_ready1); end
    req_valid1 = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    req_valid1 = 4'b0100; #1;
    total++; if (req_ready1 !== 4'b0100) begin bad++; $display("FAIL rb_grant2: got %b want 0100", req_ready1); end
    @(negedge clk); req_valid1 = 4'b0000;
    #2 rst = 1'b1;
    #1;
    total++; if (mul_a1 !== 32'h0 || mul_b1 !== 32'h0) begin bad++; $display("FAIL rb_mul_clear: got %h/%h want 0/0", mul_a1, mul_b1); end
    total++; if (rsp_valid1 !== 1'b0 || req_ready1 !== 4'b0000) begin bad++; $display("FAIL rb_out_clear: got v=%b r=%b want 0/0000", rsp_valid1, req_ready1); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL rb_no_rsp%0d: got %b want 0", c, rsp_valid1); end
    end
    req_valid1 = 4'b1111; rsp_ready1 = 1'b1; #1;
    total++; if (req_ready1 !== 4'b0001) begin bad++; $display("FAIL rb_next_grant: got %b want 0001", req_ready1); end
    @(negedge clk); req_valid1 = 4'b0000;
    @(negedge clk);
    total++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd0 || rsp_data1 !== exp_p[0]) begin bad++; $display("FAIL rb_rsp: got v=%b id=%0d d=%h want v=1 id=0 d=%h", rsp_valid1, rsp_id1, rsp_data1, exp_p[0]); end
    @(negedge clk);
    rsp_ready1 = 1'b0;
  endtask

  task automatic test_same_req();
    req_valid1 = 4'b1000; rsp_ready1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (req_ready1 !== 4'b1000) begin bad++; $display("FAIL same_grant%0d: got %b want 1000", k, req_ready1); end
      @(negedge clk);
      @(negedge clk);
      total++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd3 || rsp_data1 !== exp_p[3]) begin bad++; $display("FAIL same_rsp%0d: got v=%b id=%0d d=%h want v=1 id=3 d=%h", k, rsp_valid1, rsp_id1, rsp_data1, exp_p[3]); end
      @(negedge clk);
    end
    req_valid1 = 4'b0000; rsp_ready1 = 1'b0;
  endtask

  task automatic test_lat3();
    req_valid3 = 4'b0010; rsp_ready3 = 1'b0; #1;
    total++; if (req_ready3 !== 4'b0010) begin bad++; $display("FAIL lat3_grant: got %b want 0010", req_ready3); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid3 = 4'b0000;
      total++; if (mul_a3 !== op_a[1] || mul_b3 !== op_b[1]) begin bad++; $display("FAIL lat3_mul_hold%0d: got %h/%h want %h/%h", c, mul_a3, mul_b3, op_a[1], op_b[1]); end
      total++; if (rsp_valid3 !== 1'b0 || req_ready3 !== 4'b0000) begin bad++; $display("FAIL lat3_busy%0d: got v=%b r=%b want 0/0000", c, rsp_valid3, req_ready3); end
    end
    @(negedge clk);
    total++; if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd1) begin bad++; $display("FAIL lat3_rsp: got v=%b id=%0d want v=1 id=1", rsp_valid3, rsp_id3); end
    total++; if (rsp_data3 !== 32'h40A00000) begin bad++; $display("FAIL lat3_data: got %h want 40a00000", rsp_data3); end
    rsp_ready3 = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid3 !== 1'b0) begin bad++; $display("FAIL lat3_handshake: got %b want 0", rsp_valid3); end
    rsp_ready3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid1 = '0; rsp_ready1 = 1'b0;
    req_valid3 = '0; rsp_ready3 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a1[i*N +: N] = op_a[i];
      req_b1[i*N +: N] = op_b[i];
      req_a3[i*N +: N] = op_a[i];
      req_b3[i*N +: N] = op_b[i];
    end
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_reset_busy();
    test_same_req();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
